// File: rtl/vp_mem_pkg.sv
// Shared constants, op decode and FSM state type for the vector memory stage.
package vp_mem_pkg;

  localparam int WORD_W        = 24;
  localparam int ADDR_W        = 21;
  localparam int WORDS_PER_VEC = 8;
  localparam int VEC_W         = 192;
  localparam int SCAL_W        = 21;

  localparam int MEM_SLD = 0;
  localparam int MEM_SST = 1;
  localparam int MEM_VLD = 2;
  localparam int MEM_VST = 3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic vec;
    logic store;
  } mem_op_t;

  // Resolves multiple set bits: vector store > vector load > scalar store > scalar load.
  function automatic mem_op_t decode_op(input logic [3:0] mem);
    mem_op_t op;
    op.vec   = mem[MEM_VST] | mem[MEM_VLD];
    op.store = mem[MEM_VST] | (~mem[MEM_VLD] & mem[MEM_SST]);
    return op;
  endfunction

endpackage

// File: rtl/mem_lane_buf.sv
// Vector lane buffer: beat-indexed write for load assembly and beat-indexed
// read mux for store serialisation.
module mem_lane_buf #(
  parameter int WORD_W        = 24,
  parameter int WORDS_PER_VEC = 8,
  parameter int BEAT_W        = $clog2(WORDS_PER_VEC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [BEAT_W-1:0]               wr_beat,
  input  logic [WORD_W-1:0]               wr_data,
  input  logic [WORD_W*WORDS_PER_VEC-1:0] rd_vec,
  input  logic [BEAT_W-1:0]               rd_beat,
  output logic [WORD_W-1:0]               rd_data,
  output logic [WORD_W*WORDS_PER_VEC-1:0] buf_out
);

  logic [WORD_W-1:0] lane_reg [WORDS_PER_VEC];
  logic [WORD_W-1:0] rd_lanes [WORDS_PER_VEC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_VEC; i++) lane_reg[i] <= '0;
    end else if (wr_en) begin
      lane_reg[wr_beat] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < WORDS_PER_VEC; gi++) begin : g_lane
    assign buf_out[gi*WORD_W +: WORD_W] = lane_reg[gi];
    assign rd_lanes[gi]                 = rd_vec[gi*WORD_W +: WORD_W];
  end

  assign rd_data = rd_lanes[rd_beat];

endmodule

// File: rtl/vec_mem_stage.sv
// Memory-access stage: scalar and 8-beat vector loads/stores over a 24-bit
// word port, stalling EX/MEM while busy; non-memory ops pass through.
module vec_mem_stage #(
  parameter int WORDS_PER_VEC = 8,
  parameter int WORD_W        = 24,
  parameter int ADDR_W        = 21
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    mem,
  input  logic [1:0]                    wb,
  input  logic [ADDR_W-1:0]             r1e,
  input  logic [vp_mem_pkg::SCAL_W-1:0] r2e,
  input  logic [vp_mem_pkg::VEC_W-1:0]  r2v,
  input  logic [vp_mem_pkg::SCAL_W-1:0] resALUe,
  input  logic [vp_mem_pkg::VEC_W-1:0]  resALUve,
  input  logic [vp_mem_pkg::VEC_W-1:0]  resSum,
  input  logic [3:0]                    dest,
  output logic                          stall_o,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [WORD_W-1:0]             mem_wdata,
  input  logic [WORD_W-1:0]             mem_rdata,
  input  logic                          mem_ack,
  output logic [1:0]                    wb_out,
  output logic [3:0]                    dest_out,
  output logic [vp_mem_pkg::SCAL_W-1:0] resALUe_out,
  output logic [vp_mem_pkg::VEC_W-1:0]  resALUve_out,
  output logic [vp_mem_pkg::VEC_W-1:0]  resSum_out,
  output logic [vp_mem_pkg::SCAL_W-1:0] lde_out,
  output logic [vp_mem_pkg::VEC_W-1:0]  ldv_out
);
  import vp_mem_pkg::*;

  localparam int BEAT_W = $clog2(WORDS_PER_VEC);

  state_t               state_reg, state_next;
  logic [BEAT_W-1:0]    beat_reg;
  logic                 vec_reg, store_reg;
  logic [ADDR_W-1:0]    base_reg;
  logic [VEC_W-1:0]     st_data_reg;
  logic [1:0]           wb_hold_reg;
  logic [3:0]           dest_hold_reg;
  logic [SCAL_W-1:0]    resalue_hold_reg;
  logic [VEC_W-1:0]     resaluve_hold_reg, ressum_hold_reg;

  mem_op_t              op;
  logic                 busy, ack_beat, last_beat;
  logic [WORD_W-1:0]    beat_wdata;

  assign op        = decode_op(mem);
  assign busy      = (state_reg == BUSY);
  assign ack_beat  = busy & mem_ack;
  assign last_beat = vec_reg ? (beat_reg == BEAT_W'(WORDS_PER_VEC - 1)) : (beat_reg == '0);

  mem_lane_buf #(
    .WORD_W        (WORD_W),
    .WORDS_PER_VEC (WORDS_PER_VEC),
    .BEAT_W        (BEAT_W)
  ) u_lane_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ack_beat & vec_reg & ~store_reg),
    .wr_beat (beat_reg),
    .wr_data (mem_rdata),
    .rd_vec  (st_data_reg),
    .rd_beat (beat_reg),
    .rd_data (beat_wdata),
    .buf_out (ldv_out)
  );

  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Gated by rst_n so the stall is dropped during reset even with mem held.
        stall_o = rst_n & (|mem);
        if (|mem) state_next = BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        mem_req = 1'b1;
        mem_we  = store_reg;
        if (ack_beat && last_beat) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = busy ? (base_reg + ADDR_W'(beat_reg)) : '0;
  assign mem_wdata = (busy && store_reg) ? beat_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      beat_reg          <= '0;
      vec_reg           <= 1'b0;
      store_reg         <= 1'b0;
      base_reg          <= '0;
      st_data_reg       <= '0;
      wb_hold_reg       <= '0;
      dest_hold_reg     <= '0;
      resalue_hold_reg  <= '0;
      resaluve_hold_reg <= '0;
      ressum_hold_reg   <= '0;
      wb_out            <= '0;
      dest_out          <= '0;
      resALUe_out       <= '0;
      resALUve_out      <= '0;
      resSum_out        <= '0;
      lde_out           <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (|mem) begin
            vec_reg           <= op.vec;
            store_reg         <= op.store;
            base_reg          <= r1e;
            // Scalar store data sits in lane 0 so one serialiser serves both widths.
            st_data_reg       <= op.vec ? r2v : VEC_W'(r2e);
            beat_reg          <= '0;
            wb_hold_reg       <= wb;
            dest_hold_reg     <= dest;
            resalue_hold_reg  <= resALUe;
            resaluve_hold_reg <= resALUve;
            ressum_hold_reg   <= resSum;
            wb_out            <= '0;
          end else begin
            wb_out       <= wb;
            dest_out     <= dest;
            resALUe_out  <= resALUe;
            resALUve_out <= resALUve;
            resSum_out   <= resSum;
          end
        end
        BUSY: begin
          if (ack_beat) begin
            beat_reg <= beat_reg + BEAT_W'(1);
            if (!vec_reg && !store_reg) lde_out <= mem_rdata[SCAL_W-1:0];
            if (last_beat) begin
              wb_out       <= wb_hold_reg;
              dest_out     <= dest_hold_reg;
              resALUe_out  <= resalue_hold_reg;
              resALUve_out <= resaluve_hold_reg;
              resSum_out   <= ressum_hold_reg;
            end
          end
        end
        DONE:    wb_out <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_stage.sv
// Directed bench for vec_mem_stage with a behavioural memory responder.
module tb_vec_mem_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   mem;
  logic [1:0]   wb;
  logic [20:0]  r1e, r2e, resALUe;
  logic [191:0] r2v, resALUve, resSum;
  logic [3:0]   dest;
  logic         stall_o, mem_req, mem_we;
  logic [20:0]  mem_addr;
  logic [23:0]  mem_wdata, mem_rdata;
  logic         mem_ack, mem_ack_m, stray_ack;
  logic [1:0]   wb_out;
  logic [3:0]   dest_out;
  logic [20:0]  resALUe_out, lde_out;
  logic [191:0] resALUve_out, resSum_out, ldv_out;

  int checks = 0;
  int errors = 0;

  int rd_mode;
  bit ack_rand;
  int wait_cnt;
  logic [20:0] log_addr [$];
  logic [23:0] log_data [$];
  logic        log_we   [$];

  always #5 clk = ~clk;

  assign mem_ack = mem_ack_m | stray_ack;

  vec_mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mem),
    .wb           (wb),
    .r1e          (r1e),
    .r2e          (r2e),
    .r2v          (r2v),
    .resALUe      (resALUe),
    .resALUve     (resALUve),
    .resSum       (resSum),
    .dest         (dest),
    .stall_o      (stall_o),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .wb_out       (wb_out),
    .dest_out     (dest_out),
    .resALUe_out  (resALUe_out),
    .resALUve_out (resALUve_out),
    .resSum_out   (resSum_out),
    .lde_out      (lde_out),
    .ldv_out      (ldv_out)
  );

  // Memory responder: decides ack on the falling edge, DUT samples on the rising edge.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt == 0) begin
        mem_ack_m = 1'b1;
        mem_rdata = (rd_mode == 0) ? (24'hA00000 + {3'b000, mem_addr}) : 24'hFFFFFF;
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
        log_we.push_back(mem_we);
        $display("beat: addr=%06h we=%0d wdata=%06h rdata=%06h", mem_addr, mem_we, mem_wdata, mem_rdata);
        wait_cnt = ack_rand ? int'($urandom_range(0, 3)) : 0;
      end else begin
        mem_ack_m = 1'b0;
        wait_cnt--;
      end
    end else begin
      mem_ack_m = 1'b0;
      wait_cnt  = ack_rand ? int'($urandom_range(0, 3)) : 0;
    end
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    mem = 4'b0000;
    wb  = 2'b00;
    @(negedge clk);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_we.delete();
  endtask

  // Holds mem until the stage leaves stall (DONE); returns at DONE, negedge + 1.
  task automatic run_mem(input logic [3:0] m, input int budget, output int stall_n, output int wb_n);
    bit done = 1'b0;
    stall_n = 0;
    wb_n    = 0;
    mem     = m;
    for (int c = 0; c < budget && !done; c++) begin
      #1;
      if (wb_out != 2'b00) wb_n++;
      if (stall_o) begin
        stall_n++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    check("txn_done", done, 1);
    $display("txn: mem=%b stall_cycles=%0d wb_pulses=%0d beats=%0d", m, stall_n, wb_n, log_addr.size());
  endtask

  initial begin
    int           sn, wn;
    logic [191:0] vld_exp;
    logic [20:0]  a;

    rst_n = 1'b0; mem = '0; wb = '0; r1e = '0; r2e = '0; r2v = '0;
    resALUe = 21'h00001; resALUve = '0; resSum = '0; dest = '0;
    mem_rdata = '0; mem_ack_m = 1'b0; stray_ack = 1'b0;
    rd_mode = 0; ack_rand = 1'b0; wait_cnt = 0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wb", wb_out, 0);
    check("rst_resALUe", resALUe_out, 0);
    check("rst_lde", lde_out, 0);
    check("rst_ldv", ldv_out, 0);

    // Non-memory pass-through
    @(negedge clk);
    rst_n = 1'b1;
    resALUe = 21'h0ABCD; wb = 2'b01; dest = 4'd3;
    #1 check("pt_stall_pre", stall_o, 0);
    @(negedge clk);
    #1;
    check("pt_resALUe", resALUe_out, 21'h0ABCD);
    check("pt_wb", wb_out, 2'b01);
    check("pt_dest", dest_out, 4'd3);
    check("pt_stall", stall_o, 0);
    $display("txn: passthrough resALUe_out=%05h wb_out=%b", resALUe_out, wb_out);

    // Vector store, zero-wait
    idle_cycle();
    clear_log();
    r1e = 21'h000100;
    for (int k = 0; k < 8; k++) r2v[k*24 +: 24] = 24'(k + 1);
    wb = 2'b10; dest = 4'd5; resALUe = 21'h00011;
    run_mem(4'b1000, 30, sn, wn);
    check("vst_dest", dest_out, 4'd5);
    check("vst_wb_done", wb_out, 2'b10);
    check("vst_resALUe", resALUe_out, 21'h00011);
    idle_cycle();
    #1 check("vst_wb_after", wb_out, 2'b00);
    check("vst_stall_cycles", sn, 9);
    check("vst_wb_pulses", wn, 1);
    check("vst_beats", log_addr.size(), 8);
    for (int k = 0; k < 8 && k < log_addr.size(); k++) begin
      check("vst_addr", log_addr[k], 21'h000100 + 21'(k));
      check("vst_data", log_data[k], 24'(k + 1));
      check("vst_we", log_we[k], 1);
    end

    // Vector load, wrapping address, random ack delays
    clear_log();
    rd_mode = 0; ack_rand = 1'b1;
    r1e = 21'h1FFFFE; wb = 2'b11;
    run_mem(4'b0100, 80, sn, wn);
    mem = 4'b0000; wb = 2'b00; ack_rand = 1'b0;
    check("vld_wb_pulses", wn, 1);
    check("vld_stall_min", (sn >= 9), 1);
    check("vld_beats", log_addr.size(), 8);
    for (int k = 0; k < 8; k++) begin
      a = 21'h1FFFFE + 21'(k);
      vld_exp[k*24 +: 24] = 24'hA00000 + {3'b000, a};
      if (k < log_addr.size()) begin
        check("vld_addr", log_addr[k], a);
        check("vld_we", log_we[k], 0);
      end
    end
    check("vld_addr_wrap2", vld_exp[2*24 +: 24], 24'hA00000);
    check("vld_data", ldv_out, vld_exp);
    @(negedge clk);

    // Scalar load, rdata all ones
    clear_log();
    rd_mode = 1; r1e = 21'h000055; wb = 2'b01;
    run_mem(4'b0001, 10, sn, wn);
    idle_cycle();
    check("sld_lde", lde_out, 21'h1FFFFF);
    check("sld_stall_cycles", sn, 2);
    check("sld_addr", log_addr.size() > 0 ? log_addr[0] : 21'h0, 21'h000055);
    check("sld_ldv_kept", ldv_out, vld_exp);

    // Scalar store
    clear_log();
    r1e = 21'h000200; r2e = 21'h12345; wb = 2'b01;
    run_mem(4'b0010, 10, sn, wn);
    idle_cycle();
    check("sst_beats", log_addr.size(), 1);
    check("sst_wdata", log_data.size() > 0 ? log_data[0] : 24'h0, 24'h012345);
    check("sst_we", log_we.size() > 0 ? log_we[0] : 1'b0, 1);
    check("sst_lde_kept", lde_out, 21'h1FFFFF);

    // All mem bits set: vector store wins
    clear_log();
    r1e = 21'h000300; r2e = 21'h00007; wb = 2'b10;
    for (int k = 0; k < 8; k++) r2v[k*24 +: 24] = 24'hC00000 | 24'(k);
    run_mem(4'b1111, 30, sn, wn);
    idle_cycle();
    check("all_stall_cycles", sn, 9);
    check("all_beats", log_addr.size(), 8);
    for (int k = 0; k < 8 && k < log_addr.size(); k++) begin
      check("all_addr", log_addr[k], 21'h000300 + 21'(k));
      check("all_data", log_data[k], 24'hC00000 | 24'(k));
      check("all_we", log_we[k], 1);
    end
    check("all_ldv_kept", ldv_out, vld_exp);
    check("all_lde_kept", lde_out, 21'h1FFFFF);

    // Stray ack while idle
    clear_log();
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #1;
    check("stray_req", mem_req, 0);
    check("stray_stall", stall_o, 0);
    check("stray_lde", lde_out, 21'h1FFFFF);
    check("stray_beats", log_addr.size(), 0);
    $display("txn: stray ack ignored lde_out=%05h", lde_out);

    // Reset after beat 3 of a vector load
    @(negedge clk);
    clear_log();
    rd_mode = 0; r1e = 21'h000010;
    mem = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (log_addr.size() >= 4) break;
    end
    check("mid_beats", log_addr.size(), 4);
    check("mid_lane3", ldv_out[3*24 +: 24], 24'hA00013);
    rst_n = 1'b0;
    #1;
    check("mid_req", mem_req, 0);
    check("mid_stall", stall_o, 0);
    check("mid_addr", mem_addr, 0);
    check("mid_ldv", ldv_out, 0);
    check("mid_lde", lde_out, 0);
    check("mid_wb", wb_out, 0);
    $display("txn: reset mid-transfer mem_req=%0d", mem_req);
    mem = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    clear_log();
    r1e = 21'h000077; wb = 2'b01;
    run_mem(4'b0001, 10, sn, wn);
    check("post_wb", wb_out, 2'b01);
    idle_cycle();
    check("post_lde", lde_out, 21'h000077);
    check("post_stall_cycles", sn, 2);
    check("post_wb_pulses", wn, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
